// File: rtl/core_mrpnwp_pkg.sv
// Shared geometry, tracker entry type and address-to-physical mapping for the
// multi-port core physical-side stages.
package core_mrpnwp_pkg;

    localparam int WIDTH   = 32;
    localparam int NUMVBNK = 8;
    localparam int BITVBNK = $clog2(NUMVBNK);
    localparam int BITVROW = 10;
    localparam int BITPADR = BITVBNK + BITVROW;

    typedef struct packed {
        logic               vld;
        logic [BITPADR-1:0] padr;
        logic               fwd_hit;
        logic [WIDTH-1:0]   fwd_data;
    } rd_trk_t;

    localparam int TRK_BITS = $bits(rd_trk_t);

    // Low address bits select the bank; the bank lands in the top of padr.
    function automatic logic [BITPADR-1:0] addr2padr(input logic [BITPADR-1:0] addr);
        return {addr[BITVBNK-1:0], addr[BITVBNK +: BITVROW]};
    endfunction

endpackage

// File: rtl/core_mrpnwp_rdtrk.sv
// Per-port read tracker: a DEPTH-deep shift register of rd_trk_t entries that
// follows each issued read through the SRAM latency, cleared by rst.
module core_mrpnwp_rdtrk
    import core_mrpnwp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int BITS  = TRK_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout
);

    logic [BITS-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_reg[s] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage_reg[s] <= stage_reg[s-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/core_mrpnwp_1r1w_rdpipe.sv
// Physical-side read/write pipe: issues legal requests to the t1 SRAM ports,
// tracks reads through the SRAM latency and forwards same-cycle write data.
module core_mrpnwp_1r1w_rdpipe
    import core_mrpnwp_pkg::*;
#(
    parameter int NUMRDPT    = 2,
    parameter int NUMWRPT    = 3,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int SRAM_DELAY = 2,
    parameter int BITFCNT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUMRDPT-1:0]           pread,
    input  logic [NUMRDPT*BITADDR-1:0]   pradr,
    input  logic [NUMWRPT-1:0]           pwrite,
    input  logic [NUMWRPT*BITADDR-1:0]   pwradr,
    input  logic [NUMWRPT*WIDTH-1:0]     pdin,
    output logic [NUMRDPT-1:0]           t1_readA,
    output logic [NUMRDPT*BITPADR-1:0]   t1_addrA,
    input  logic [NUMRDPT*WIDTH-1:0]     t1_doutA,
    output logic [NUMWRPT-1:0]           t1_writeB,
    output logic [NUMWRPT*BITPADR-1:0]   t1_addrB,
    output logic [NUMWRPT*WIDTH-1:0]     t1_dinB,
    output logic [NUMRDPT-1:0]           vread_vld_bus,
    output logic [NUMRDPT*BITPADR-1:0]   vread_padr_bus,
    output logic [NUMRDPT*WIDTH-1:0]     t1_doutB,
    output logic [NUMRDPT+NUMWRPT-1:0]   addr_err,
    output logic [BITFCNT-1:0]           fwd_cnt
);

    logic [NUMRDPT-1:0]         rd_legal;
    logic [NUMWRPT-1:0]         wr_legal;
    logic [NUMRDPT-1:0]         rd_hit;
    logic [NUMRDPT*WIDTH-1:0]   rd_fwd_data;

    logic [NUMRDPT+NUMWRPT-1:0] addr_err_reg;
    logic [BITFCNT-1:0]         fwd_cnt_reg;
    logic [BITFCNT-1:0]         fwd_cnt_next;
    logic [BITFCNT+7:0]         fwd_sum;

    genvar gi;

    generate
        for (gi = 0; gi < NUMRDPT; gi++) begin : g_rd_legal
            assign rd_legal[gi] = pread[gi] &&
                                  (32'(pradr[gi*BITADDR +: BITADDR]) < 32'(NUMADDR));
        end
        for (gi = 0; gi < NUMWRPT; gi++) begin : g_wr_legal
            assign wr_legal[gi] = pwrite[gi] &&
                                  (32'(pwradr[gi*BITADDR +: BITADDR]) < 32'(NUMADDR));
        end
    endgenerate

    always_comb begin
        rd_hit      = '0;
        rd_fwd_data = '0;
        for (int r = 0; r < NUMRDPT; r++) begin
            // Ascending scan so the highest-index matching write port wins.
            for (int w = 0; w < NUMWRPT; w++) begin
                if (rd_legal[r] && wr_legal[w] &&
                    (pwradr[w*BITADDR +: BITADDR] == pradr[r*BITADDR +: BITADDR])) begin
                    rd_hit[r]                     = 1'b1;
                    rd_fwd_data[r*WIDTH +: WIDTH] = pdin[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUMRDPT; gi++) begin : g_rd
            rd_trk_t            iss_trk_reg;
            rd_trk_t            trk_tail;
            logic [BITPADR-1:0] padr_hold_reg;
            logic [WIDTH-1:0]   dout_hold_reg;
            logic [WIDTH-1:0]   ret_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    iss_trk_reg <= '0;
                end else begin
                    iss_trk_reg.vld <= rd_legal[gi];
                    if (rd_legal[gi]) begin
                        iss_trk_reg.padr     <= addr2padr(pradr[gi*BITADDR +: BITPADR]);
                        iss_trk_reg.fwd_hit  <= rd_hit[gi];
                        iss_trk_reg.fwd_data <= rd_fwd_data[gi*WIDTH +: WIDTH];
                    end
                end
            end

            core_mrpnwp_rdtrk #(
                .DEPTH (SRAM_DELAY),
                .BITS  (TRK_BITS)
            ) u_rdtrk (
                .clk  (clk),
                .rst  (rst),
                .din  (iss_trk_reg),
                .dout (trk_tail)
            );

            assign ret_data = trk_tail.fwd_hit ? trk_tail.fwd_data
                                               : t1_doutA[gi*WIDTH +: WIDTH];

            // Return buses keep the last delivered read between valid cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    padr_hold_reg <= '0;
                    dout_hold_reg <= '0;
                end else if (trk_tail.vld) begin
                    padr_hold_reg <= trk_tail.padr;
                    dout_hold_reg <= ret_data;
                end
            end

            assign t1_readA[gi]                       = iss_trk_reg.vld;
            assign t1_addrA[gi*BITPADR +: BITPADR]    = iss_trk_reg.padr;
            assign vread_vld_bus[gi]                  = trk_tail.vld;
            assign vread_padr_bus[gi*BITPADR +: BITPADR] =
                trk_tail.vld ? trk_tail.padr : padr_hold_reg;
            assign t1_doutB[gi*WIDTH +: WIDTH]        =
                trk_tail.vld ? ret_data : dout_hold_reg;
        end

        for (gi = 0; gi < NUMWRPT; gi++) begin : g_wr
            logic               write_reg;
            logic [BITPADR-1:0] addr_reg;
            logic [WIDTH-1:0]   din_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    write_reg <= 1'b0;
                    addr_reg  <= '0;
                    din_reg   <= '0;
                end else begin
                    write_reg <= wr_legal[gi];
                    if (wr_legal[gi]) begin
                        addr_reg <= addr2padr(pwradr[gi*BITADDR +: BITPADR]);
                        din_reg  <= pdin[gi*WIDTH +: WIDTH];
                    end
                end
            end

            assign t1_writeB[gi]                   = write_reg;
            assign t1_addrB[gi*BITPADR +: BITPADR] = addr_reg;
            assign t1_dinB[gi*WIDTH +: WIDTH]      = din_reg;
        end
    endgenerate

    // Extra headroom bits detect overflow so the counter pins at all-ones.
    always_comb begin
        fwd_sum = (BITFCNT+8)'(fwd_cnt_reg);
        for (int r = 0; r < NUMRDPT; r++) begin
            fwd_sum = fwd_sum + (BITFCNT+8)'(rd_hit[r]);
        end
        fwd_cnt_next = (|fwd_sum[BITFCNT+7:BITFCNT]) ? '1 : fwd_sum[BITFCNT-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_reg <= '0;
            fwd_cnt_reg  <= '0;
        end else begin
            addr_err_reg <= {pwrite & ~wr_legal, pread & ~rd_legal};
            fwd_cnt_reg  <= fwd_cnt_next;
        end
    end

    assign addr_err = addr_err_reg;
    assign fwd_cnt  = fwd_cnt_reg;

endmodule

// File: tb/tb_core_mrpnwp_1r1w_rdpipe.sv
// Self-checking bench: behavioural SRAM plus an address/forwarding reference
// model, with directed scenarios followed by randomized traffic.
module tb_core_mrpnwp_1r1w_rdpipe;

    localparam int NR   = 2;
    localparam int NW   = 3;
    localparam int BA   = 14;
    localparam int NA   = 8192;
    localparam int D    = 2;
    localparam int BF   = 4;
    localparam int W    = 32;
    localparam int BP   = 13;
    localparam int FMAX = (1 << BF) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    pread;
    logic [NR*BA-1:0] pradr;
    logic [NW-1:0]    pwrite;
    logic [NW*BA-1:0] pwradr;
    logic [NW*W-1:0]  pdin;
    logic [NR-1:0]    t1_readA;
    logic [NR*BP-1:0] t1_addrA;
    logic [NR*W-1:0]  t1_doutA;
    logic [NW-1:0]    t1_writeB;
    logic [NW*BP-1:0] t1_addrB;
    logic [NW*W-1:0]  t1_dinB;
    logic [NR-1:0]    vread_vld_bus;
    logic [NR*BP-1:0] vread_padr_bus;
    logic [NR*W-1:0]  t1_doutB;
    logic [NR+NW-1:0] addr_err;
    logic [BF-1:0]    fwd_cnt;

    core_mrpnwp_1r1w_rdpipe #(
        .NUMRDPT(NR), .NUMWRPT(NW), .NUMADDR(NA), .BITADDR(BA),
        .SRAM_DELAY(D), .BITFCNT(BF)
    ) dut (
        .clk(clk), .rst(rst),
        .pread(pread), .pradr(pradr),
        .pwrite(pwrite), .pwradr(pwradr), .pdin(pdin),
        .t1_readA(t1_readA), .t1_addrA(t1_addrA), .t1_doutA(t1_doutA),
        .t1_writeB(t1_writeB), .t1_addrB(t1_addrB), .t1_dinB(t1_dinB),
        .vread_vld_bus(vread_vld_bus), .vread_padr_bus(vread_padr_bus),
        .t1_doutB(t1_doutB), .addr_err(addr_err), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: returns the contents of the issued padr D cycles later.
    logic [W-1:0]  mem [1 << BP];
    logic [BP-1:0] sram_adr [NR][D];
    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            sram_adr[r][0] <= t1_addrA[r*BP +: BP];
            for (int s = 1; s < D; s++) sram_adr[r][s] <= sram_adr[r][s-1];
        end
    end
    for (genvar gi = 0; gi < NR; gi++) begin : g_sram
        assign t1_doutA[gi*W +: W] = mem[sram_adr[gi][D-1]];
    end

    typedef struct packed {
        int unsigned   cyc;
        logic [BP-1:0] padr;
        logic [W-1:0]  data;
    } ret_t;

    ret_t exp_q [NR][$];
    ret_t obs_q [NR][$];
    int   exp_fwd;
    logic [NR+NW-1:0] exp_err;

    int unsigned  ra [NR];
    int unsigned  wa [NW];
    logic [W-1:0] wd [NW];

    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (vread_vld_bus[r] === 1'b1) begin
                ret_t o;
                o.cyc  = cyc;
                o.padr = vread_padr_bus[r*BP +: BP];
                o.data = t1_doutB[r*W +: W];
                obs_q[r].push_back(o);
            end
        end
    end

    // bank = addr mod 8 in the top of padr, row = (addr / 8) mod 1024 below it.
    function automatic logic [BP-1:0] map_padr(input int unsigned a);
        return BP'((a % 8) * 1024 + (a / 8) % 1024);
    endfunction

    function automatic int unsigned pick_addr();
        int unsigned k = $urandom_range(0, 31);
        if (k < 3) return NA + $urandom_range(0, NA - 1);
        return k * 257;
    endfunction

    task automatic clear_sb();
        for (int r = 0; r < NR; r++) begin
            exp_q[r].delete();
            obs_q[r].delete();
        end
    endtask

    task automatic idle(input int n);
        pread  = '0;
        pwrite = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_fwd = 0;
        clear_sb();
    endtask

    // Drives one request cycle from ra/wa/wd and records the model's expectations.
    task automatic drive(input logic [NR-1:0] rd, input logic [NW-1:0] wr);
        int hits = 0;
        exp_err = '0;
        for (int r = 0; r < NR; r++) begin
            pread[r]            = rd[r];
            pradr[r*BA +: BA]   = BA'(ra[r]);
            if (rd[r] && ra[r] >= NA) exp_err[r] = 1'b1;
        end
        for (int w = 0; w < NW; w++) begin
            pwrite[w]           = wr[w];
            pwradr[w*BA +: BA]  = BA'(wa[w]);
            pdin[w*W +: W]      = wd[w];
            if (wr[w] && wa[w] >= NA) exp_err[NR+w] = 1'b1;
        end
        for (int r = 0; r < NR; r++) begin
            if (rd[r] && ra[r] < NA) begin
                ret_t e;
                logic hit;
                hit    = 1'b0;
                e.cyc  = cyc + 1 + D;
                e.padr = map_padr(ra[r]);
                e.data = mem[e.padr];
                for (int w = 0; w < NW; w++) begin
                    if (wr[w] && wa[w] == ra[r]) begin
                        e.data = wd[w];
                        hit    = 1'b1;
                    end
                end
                if (hit) hits++;
                exp_q[r].push_back(e);
            end
        end
        exp_fwd = (exp_fwd + hits > FMAX) ? FMAX : exp_fwd + hits;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        total++;
        if ({t1_readA, t1_writeB, vread_vld_bus, addr_err, fwd_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_enables got %h want 0",
                     {t1_readA, t1_writeB, vread_vld_bus, addr_err, fwd_cnt});
        end
        total++;
        if ({t1_addrA, t1_addrB, t1_dinB, vread_padr_bus, t1_doutB} !== '0) begin
            bad++;
            $display("FAIL reset_data got %h want 0",
                     {t1_addrA, t1_addrB, t1_dinB, vread_padr_bus, t1_doutB});
        end
        rst = 1'b0;
        exp_fwd = 0;
        clear_sb();
    endtask

    task automatic test_single();
        ra[0] = 32'h00B;
        ra[1] = 0;
        drive(2'b01, 3'b000);
        total++;
        if (t1_readA !== 2'b01 || t1_addrA[BP-1:0] !== 13'h0C01) begin
            bad++;
            $display("FAIL single_issue got rd=%b adr=%h want rd=01 adr=0c01",
                     t1_readA, t1_addrA[BP-1:0]);
        end
        idle(1);
        total++;
        if (vread_vld_bus !== 2'b00) begin
            bad++;
            $display("FAIL single_early got vld=%b want 00", vread_vld_bus);
        end
        idle(1);
        total++;
        if (vread_vld_bus !== 2'b01 || t1_doutB[W-1:0] !== 32'hDEADBEEF ||
            vread_padr_bus[BP-1:0] !== 13'h0C01) begin
            bad++;
            $display("FAIL single_return got vld=%b padr=%h data=%h want 01 0c01 deadbeef",
                     vread_vld_bus, vread_padr_bus[BP-1:0], t1_doutB[W-1:0]);
        end
        idle(1);
        total++;
        if (vread_vld_bus !== 2'b00 || t1_doutB[W-1:0] !== 32'hDEADBEEF ||
            vread_padr_bus[BP-1:0] !== 13'h0C01) begin
            bad++;
            $display("FAIL single_hold got vld=%b padr=%h data=%h want 00 0c01 deadbeef",
                     vread_vld_bus, vread_padr_bus[BP-1:0], t1_doutB[W-1:0]);
        end
        clear_sb();
    endtask

    task automatic test_forward();
        ra[0] = 32'h40; ra[1] = 0;
        wa[0] = 0;      wa[1] = 32'h40; wa[2] = 32'h40;
        wd[0] = 0;      wd[1] = 32'h11; wd[2] = 32'h22;
        drive(2'b01, 3'b110);
        total++;
        if (fwd_cnt !== BF'(exp_fwd) || exp_fwd != 1) begin
            bad++;
            $display("FAIL fwd_count got %0d want 1", fwd_cnt);
        end
        idle(2);
        total++;
        if (vread_vld_bus[0] !== 1'b1 || t1_doutB[W-1:0] !== 32'h22) begin
            bad++;
            $display("FAIL fwd_data got vld=%b data=%h want 1 00000022",
                     vread_vld_bus[0], t1_doutB[W-1:0]);
        end
        drive(2'b01, 3'b000);
        wd[2] = 32'h33;
        drive(2'b00, 3'b100);
        total++;
        if (fwd_cnt !== BF'(exp_fwd)) begin
            bad++;
            $display("FAIL fwd_late_count got %0d want %0d", fwd_cnt, exp_fwd);
        end
        idle(1);
        total++;
        if (vread_vld_bus[0] !== 1'b1 || t1_doutB[W-1:0] !== mem[map_padr(32'h40)]) begin
            bad++;
            $display("FAIL fwd_late_data got vld=%b data=%h want 1 %h",
                     vread_vld_bus[0], t1_doutB[W-1:0], mem[map_padr(32'h40)]);
        end
        clear_sb();
    endtask

    task automatic test_addr_err();
        ra[0] = 5;  ra[1] = NA;
        wa[0] = NA; wa[1] = 0; wa[2] = 300;
        wd[2] = 32'hA5A5_0300;
        drive(2'b10, 3'b101);
        total++;
        if (addr_err !== exp_err) begin
            bad++;
            $display("FAIL err_pulse got %b want %b", addr_err, exp_err);
        end
        total++;
        if (t1_readA !== 2'b00 || t1_writeB !== 3'b100 ||
            t1_addrB[2*BP +: BP] !== map_padr(300)) begin
            bad++;
            $display("FAIL err_issue got rd=%b wr=%b adr=%h want 00 100 %h",
                     t1_readA, t1_writeB, t1_addrB[2*BP +: BP], map_padr(300));
        end
        idle(1);
        total++;
        if (addr_err !== '0) begin
            bad++;
            $display("FAIL err_clear got %b want 0", addr_err);
        end
        idle(1);
        total++;
        if (vread_vld_bus !== 2'b00) begin
            bad++;
            $display("FAIL err_noreturn got vld=%b want 00", vread_vld_bus);
        end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        clear_sb();
        for (int i = 0; i < 20; i++) begin
            ra[0] = $urandom_range(0, NA - 1);
            ra[1] = $urandom_range(0, NA - 1);
            drive(2'b11, 3'b000);
        end
        idle(D + 2);
        for (int r = 0; r < NR; r++) begin
            total++;
            if (obs_q[r].size() != exp_q[r].size()) begin
                bad++;
                $display("FAIL b2b_count port%0d got %0d want %0d",
                         r, obs_q[r].size(), exp_q[r].size());
            end
            while (exp_q[r].size() > 0 && obs_q[r].size() > 0) begin
                ret_t e;
                ret_t o;
                e = exp_q[r].pop_front();
                o = obs_q[r].pop_front();
                total++;
                $display("b2b port%0d cyc=%0d padr=%h data=%h", r, o.cyc, o.padr, o.data);
                if (o !== e) begin
                    bad++;
                    $display("FAIL b2b_ret port%0d got cyc=%0d padr=%h data=%h want cyc=%0d padr=%h data=%h",
                             r, o.cyc, o.padr, o.data, e.cyc, e.padr, e.data);
                end
            end
        end
        clear_sb();
    endtask

    task automatic test_reset_midflight();
        ra[0] = 200; ra[1] = 77;
        wa[1] = 200; wd[1] = 32'h1234_5678;
        drive(2'b11, 3'b010);
        drive(2'b11, 3'b000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pread  = '0;
        pwrite = '0;
        exp_fwd = 0;
        clear_sb();
        total++;
        if ({vread_vld_bus, t1_readA, fwd_cnt, vread_padr_bus, t1_doutB} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got vld=%b rd=%b fwd=%0d padr=%h data=%h want all 0",
                     vread_vld_bus, t1_readA, fwd_cnt, vread_padr_bus, t1_doutB);
        end
        idle(D + 4);
        for (int r = 0; r < NR; r++) begin
            total++;
            if (obs_q[r].size() != 0) begin
                bad++;
                $display("FAIL midrst_ghost port%0d got %0d returns want 0", r, obs_q[r].size());
            end
        end
        clear_sb();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ra[0] = i * 8 + 1;
            wa[2] = i * 8 + 1;
            wd[2] = $urandom();
            drive(2'b01, 3'b100);
            total++;
            if (fwd_cnt !== BF'(exp_fwd)) begin
                bad++;
                $display("FAIL sat_step%0d got %0d want %0d", i, fwd_cnt, exp_fwd);
            end
        end
        total++;
        if (fwd_cnt !== 4'hF) begin
            bad++;
            $display("FAIL sat_final got %0d want 15", fwd_cnt);
        end
        idle(D + 2);
        clear_sb();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < NR; r++) ra[r] = pick_addr();
            for (int w = 0; w < NW; w++) begin
                wa[w] = pick_addr();
                wd[w] = $urandom();
            end
            drive(NR'($urandom_range(0, 3)), NW'($urandom_range(0, 7)));
            total++;
            if (addr_err !== exp_err || fwd_cnt !== BF'(exp_fwd)) begin
                bad++;
                $display("FAIL rand_cycle%0d got err=%b fwd=%0d want err=%b fwd=%0d",
                         i, addr_err, fwd_cnt, exp_err, exp_fwd);
            end
        end
        idle(D + 2);
        for (int r = 0; r < NR; r++) begin
            total++;
            if (obs_q[r].size() != exp_q[r].size()) begin
                bad++;
                $display("FAIL rand_count port%0d got %0d want %0d",
                         r, obs_q[r].size(), exp_q[r].size());
            end
            while (exp_q[r].size() > 0 && obs_q[r].size() > 0) begin
                ret_t e;
                ret_t o;
                e = exp_q[r].pop_front();
                o = obs_q[r].pop_front();
                total++;
                $display("rand port%0d cyc=%0d padr=%h data=%h", r, o.cyc, o.padr, o.data);
                if (o !== e) begin
                    bad++;
                    $display("FAIL rand_ret port%0d got cyc=%0d padr=%h data=%h want cyc=%0d padr=%h data=%h",
                             r, o.cyc, o.padr, o.data, e.cyc, e.padr, e.data);
                end
            end
        end
        clear_sb();
    endtask

    initial begin
        for (int i = 0; i < (1 << BP); i++) mem[i] = $urandom();
        mem[13'h0C01] = 32'hDEADBEEF;
        rst     = 1'b1;
        pread   = '0;
        pradr   = '0;
        pwrite  = '0;
        pwradr  = '0;
        pdin    = '0;
        exp_fwd = 0;
        exp_err = '0;
        for (int r = 0; r < NR; r++) ra[r] = 0;
        for (int w = 0; w < NW; w++) begin
            wa[w] = 0;
            wd[w] = '0;
        end

        test_reset();
        test_single();
        test_forward();
        test_addr_err();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
